// File: rtl/axil_mem_responder_if.sv
// AXI4-Lite slave channels plus the single-beat memory request/response bus.
interface axil_mem_responder_if;
    logic [31:0] s_araddr;
    logic        s_arready;
    logic        s_arvalid;
    logic [2:0]  s_arprot;
    logic [31:0] s_rdata;
    logic        s_rready;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic [31:0] s_awaddr;
    logic        s_awready;
    logic        s_awvalid;
    logic [2:0]  s_awprot;
    logic [31:0] s_wdata;
    logic        s_wready;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_bready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        mem_request_enable;
    logic        mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_response_enable;
    logic [31:0] mem_data;

    modport slave (
        input  s_araddr, s_arvalid, s_arprot, s_rready,
        input  s_awaddr, s_awvalid, s_awprot,
        input  s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output mem_request_enable, mem_mode, mem_addr,
        output mem_wdata, mem_wstrb,
        input  mem_response_enable, mem_data
    );

    modport master (
        output s_araddr, s_arvalid, s_arprot, s_rready,
        output s_awaddr, s_awvalid, s_awprot,
        output s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  mem_request_enable, mem_mode, mem_addr,
        input  mem_wdata, mem_wstrb,
        output mem_response_enable, mem_data
    );
endinterface

// File: rtl/axil_mem_responder.sv
// AXI4-Lite slave turning each read/write into one memory request pulse.
// Optional AXIL_RESP_TIMEOUT_EN adds a SLVERR timeout on the memory response.
module axil_mem_responder #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 rst,
    axil_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, MEM_RD, MEM_WR, RESP_R, RESP_B
    } state_t;

    state_t      state;
    logic        aw_rdy, w_rdy, ar_rdy;
    logic        aw_got, w_got;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        rvalid, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        req, mode;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mwstrb;

    logic        aw_hs, w_hs, ar_hs, wr_done, wr_part;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        mem_done;
    logic [1:0]  done_resp;
    logic [31:0] done_data;

    function automatic logic in_window(input logic [31:0] a);
        return (a & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
    endfunction

    // A pending write on either channel holds AR off in the same cycle.
    assign bus.s_arready = ar_rdy & ~(bus.s_awvalid | bus.s_wvalid);
    assign bus.s_awready = aw_rdy;
    assign bus.s_wready  = w_rdy;
    assign bus.s_rvalid  = rvalid;
    assign bus.s_rdata   = rdata;
    assign bus.s_rresp   = rresp;
    assign bus.s_bvalid  = bvalid;
    assign bus.s_bresp   = bresp;
    assign bus.mem_request_enable = req;
    assign bus.mem_mode  = mode;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;
    assign bus.mem_wstrb = mwstrb;

    logic unused_prot;
    assign unused_prot = ^{bus.s_arprot, bus.s_awprot};

    assign aw_hs   = bus.s_awvalid & aw_rdy;
    assign w_hs    = bus.s_wvalid & w_rdy;
    assign ar_hs   = bus.s_arvalid & bus.s_arready;
    assign wr_addr = aw_hs ? bus.s_awaddr : awaddr_q;
    assign wr_data = w_hs ? bus.s_wdata : wdata_q;
    assign wr_strb = w_hs ? bus.s_wstrb : wstrb_q;
    assign wr_done = (aw_hs | aw_got) & (w_hs | w_got);
    assign wr_part = aw_hs | w_hs | aw_got | w_got;

`ifdef AXIL_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          in_mem, resp_hit, tmo_hit;

    assign in_mem   = (state == MEM_RD) || (state == MEM_WR);
    assign resp_hit = in_mem & ~req & bus.mem_response_enable;
    assign tmo_hit  = in_mem & ~req &
                      (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (in_mem && !req) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // A real response in the final cycle still beats the timeout.
    always_comb begin
        mem_done  = resp_hit | tmo_hit;
        done_resp = resp_hit ? 2'b00 : 2'b10;
        done_data = resp_hit ? bus.mem_data : 32'h0;
    end
`else
    always_comb begin
        mem_done  = ~req & bus.mem_response_enable;
        done_resp = 2'b00;
        done_data = bus.mem_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            aw_rdy   <= 1'b0;
            w_rdy    <= 1'b0;
            ar_rdy   <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            req      <= 1'b0;
            mode     <= 1'b0;
            maddr    <= '0;
            mwdata   <= '0;
            mwstrb   <= '0;
        end else begin
            req <= 1'b0;
            unique case (state)
                IDLE, WR_COLLECT: begin
                    if (aw_hs) begin
                        awaddr_q <= bus.s_awaddr;
                        aw_got   <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= bus.s_wdata;
                        wstrb_q <= bus.s_wstrb;
                        w_got   <= 1'b1;
                    end
                    if (wr_done) begin
                        aw_rdy <= 1'b0;
                        w_rdy  <= 1'b0;
                        ar_rdy <= 1'b0;
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        if (in_window(wr_addr)) begin
                            req    <= 1'b1;
                            mode   <= 1'b1;
                            maddr  <= {wr_addr[31:2], 2'b00};
                            mwdata <= wr_data;
                            mwstrb <= wr_strb;
                            state  <= MEM_WR;
                        end else begin
                            bvalid <= 1'b1;
                            bresp  <= 2'b11;
                            state  <= RESP_B;
                        end
                    end else if (wr_part) begin
                        aw_rdy <= ~(aw_hs | aw_got);
                        w_rdy  <= ~(w_hs | w_got);
                        ar_rdy <= 1'b0;
                        state  <= WR_COLLECT;
                    end else if (ar_hs) begin
                        aw_rdy <= 1'b0;
                        w_rdy  <= 1'b0;
                        ar_rdy <= 1'b0;
                        if (in_window(bus.s_araddr)) begin
                            req    <= 1'b1;
                            mode   <= 1'b0;
                            maddr  <= {bus.s_araddr[31:2], 2'b00};
                            mwdata <= '0;
                            mwstrb <= '0;
                            state  <= MEM_RD;
                        end else begin
                            rvalid <= 1'b1;
                            rdata  <= '0;
                            rresp  <= 2'b11;
                            state  <= RESP_R;
                        end
                    end else begin
                        aw_rdy <= 1'b1;
                        w_rdy  <= 1'b1;
                        ar_rdy <= 1'b1;
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (mem_done) begin
                        mode   <= 1'b0;
                        maddr  <= '0;
                        mwdata <= '0;
                        mwstrb <= '0;
                        if (state == MEM_RD) begin
                            rvalid <= 1'b1;
                            rdata  <= done_data;
                            rresp  <= done_resp;
                            state  <= RESP_R;
                        end else begin
                            bvalid <= 1'b1;
                            bresp  <= done_resp;
                            state  <= RESP_B;
                        end
                    end
                end
                RESP_R: begin
                    if (bus.s_rready) begin
                        rvalid <= 1'b0;
                        rdata  <= '0;
                        rresp  <= '0;
                        aw_rdy <= 1'b1;
                        w_rdy  <= 1'b1;
                        ar_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                RESP_B: begin
                    if (bus.s_bready) begin
                        bvalid <= 1'b0;
                        bresp  <= '0;
                        aw_rdy <= 1'b1;
                        w_rdy  <= 1'b1;
                        ar_rdy <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axil_mem_responder.md
Name: axil_mem_responder

Overview:
- AXI4-Lite slave that terminates disk/memory-side transactions issued by an AXI4-Lite initiator such as the virtio block's m_spi_* port.
- Converts each accepted read or write into one request on the team's single-beat memory request/response bus (mem_request_enable / mem_response_enable).
- Returns R/B responses to the initiator.
- Sits between the virtio disk port and the backing memory/SPI storage controller.

Parameters:
- ADDR_BASE, 32'h0000_0000, base of the decoded window.
- ADDR_MASK, 32'hFF00_0000, bits compared against ADDR_BASE; mismatch gives DECERR.
- TIMEOUT_CYCLES, 1024, memory response timeout; used only with AXIL_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_araddr  in  32  read address.
- s_arready  out  1  read address ready.
- s_arvalid  in  1  read address valid.
- s_arprot  in  3  ignored.
- s_rdata  out  32  read data.
- s_rready  in  1  read data ready.
- s_rresp  out  2  read response.
- s_rvalid  out  1  read data valid.
- s_awaddr  in  32  write address.
- s_awready  out  1  write address ready.
- s_awvalid  in  1  write address valid.
- s_awprot  in  3  ignored.
- s_wdata  in  32  write data.
- s_wready  out  1  write data ready.
- s_wstrb  in  4  byte strobes.
- s_wvalid  in  1  write data valid.
- s_bready  in  1  write response ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  write response valid.
- mem_request_enable  out  1  one-cycle request pulse.
- mem_mode  out  1  0 = read, 1 = write.
- mem_addr  out  32  word address (s_*addr with bits [1:0] forced to 0).
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 4'b0000 on reads.
- mem_response_enable  in  1  one-cycle completion pulse.
- mem_data  in  32  read data, valid with mem_response_enable.

Behaviour:
- Reset (rst high, asynchronous): all outputs 0 and FSM in IDLE. Reset mid-transaction aborts it; no R/B is produced afterwards, and a late mem_response_enable is ignored.
- All outputs are registered. Exactly one transaction is outstanding at a time.
- FSM states: IDLE, WR_COLLECT, MEM_RD, MEM_WR, RESP_R, RESP_B.
- IDLE: s_arready = s_awready = s_wready = 1.
  - AW and W may handshake in the same or different cycles; the address, data and strobes are latched.
  - If both AW and W are captured, go to MEM_WR. If only one is captured, go to WR_COLLECT.
  - Otherwise, if AR handshakes, latch the address and go to MEM_RD.
- Priority: when AW/W and AR are valid in the same IDLE cycle, the write wins. s_arready is driven 0 that cycle (arready = !(awvalid|wvalid)), so AR is held off.
- WR_COLLECT: only the missing channel's ready is 1; AR is not accepted. Once the missing channel arrives, go to MEM_WR.
- MEM_RD / MEM_WR:
  - On entry, pulse mem_request_enable for exactly 1 cycle with mem_mode/addr/wdata/wstrb stable; these hold until the response.
  - mem_response_enable is sampled from the cycle after the pulse onward.
  - On response: MEM_RD latches mem_data into s_rdata, sets s_rresp = 2'b00 and s_rvalid = 1, then goes to RESP_R. MEM_WR sets s_bresp = 2'b00 and s_bvalid = 1, then goes to RESP_B.
- Address decode: if (addr & ADDR_MASK) != (ADDR_BASE & ADDR_MASK), skip the memory request and go straight to RESP_R/RESP_B with resp = 2'b11 (DECERR) and rdata = 0.
- RESP_R / RESP_B: valid is held with stable payload until the ready handshake, then go to IDLE. Valid and payload return to 0 on the handshake cycle edge.
- Latency: AR handshake at cycle N → request pulse at N+1. Response at cycle M → s_rvalid at M+1. Minimum read latency is 3 cycles from AR to rvalid, with a zero-wait memory responding at N+2.
- Spurious mem_response_enable outside MEM_RD/MEM_WR is ignored.
- Unaligned addresses: low 2 bits are dropped; no error.

Optional Feature:
- Macro AXIL_RESP_TIMEOUT_EN.
- Defined: a counter runs in MEM_RD/MEM_WR. If TIMEOUT_CYCLES cycles elapse after the request pulse with no response, the block completes with resp = 2'b10 (SLVERR) and rdata = 0, then returns to IDLE. A response arriving after the timeout is ignored.
- Undefined: no counter; the block waits indefinitely for mem_response_enable.

Test Plan:
- Read: AR 32'h0000_1004 and a memory model replying 32'hDEAD_BEEF 2 cycles after the pulse → mem_addr 32'h0000_1004, mem_mode 0, mem_wstrb 0; rvalid with rdata 32'hDEAD_BEEF, rresp 00.
- Write with W one cycle before AW: wdata 32'h1234_5678, wstrb 4'b0011, addr 32'h0000_0020 → single pulse with mem_mode 1, mem_wstrb 4'b0011; bvalid, bresp 00.
- Simultaneous AW/W/AR in IDLE → write completes first (B), then the read is accepted; exactly 2 request pulses, in write-then-read order.
- Out-of-window read addr 32'h8000_0000 (defaults) → no mem_request_enable; rresp 11, rdata 0.
- Backpressure: rready held 0 for 5 cycles → rvalid/rdata stable throughout, AR not accepted until the handshake; rst pulsed during MEM_RD → all outputs 0, later response ignored.
- With AXIL_RESP_TIMEOUT_EN and TIMEOUT_CYCLES = 16: no memory response → bresp 10 on the 17th cycle after the pulse.
